aes_key_schedule_seq: RTL and testbench

Sequential AES-128 key-schedule engine that sits between the key loader and the cipher round datapath. It accepts one 128-bit cipher key over a valid/ready handshake. It then walks rounds 0..NR, using the existing combinational single-step expander (KeyExpansionComb128) once per round. Each round key is streamed to the round datapath over a second valid/ready handshake, so the cipher core consumes one round key per round without storing the whole schedule.

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/aes_key_schedule_seq_expand.sv | 16 +
 rtl/aes_key_schedule_seq.sv | 66 ++++++
 tb/tb_aes_key_schedule_seq.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, FSM states and GF(2^8) helpers for the key schedule
package aes_pkg;
   localparam int AES_NR = 10;
   typedef logic [31:0] word_t;
   typedef logic [127:0] block_t;
   typedef enum logic {IDLE, EMIT} ks_state_t;
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, s;
      p = 8'h00;
      s = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ s;
         s = xtime(s);
      end
      return p;
   endfunction
   // S-box = affine(x^254); the power chain maps 0 to 0 with no special case
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] r, s;
      r = 8'h01;
      s = x;
      for (int i = 1; i < 8; i++) begin
         s = gf_mul(s, s);
         r = gf_mul(r, s);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction
   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      logic [7:0] c;
      c = 8'h01;
      for (int i = 1; i < 10; i++)
         if (i < int'(rnd)) c = xtime(c);
      return c;
   endfunction
   function automatic word_t sub_word(input word_t w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction
   function automatic word_t rot_word(input word_t w);
      return {w[23:0], w[31:24]};
   endfunction
endpackage

// File: rtl/aes_key_schedule_seq_expand.sv
// KeyExpansionComb128: one combinational AES-128 key-expansion step (round key r-1 -> r)
module KeyExpansionComb128
   import aes_pkg::*;
(
   input  block_t     prev_key,
   input  logic [3:0] round,
   output block_t     next_key
);
   word_t t, n0, n1, n2, n3;
   assign t  = sub_word(rot_word(prev_key[31:0])) ^ {rcon(round), 24'h000000};
   assign n0 = prev_key[127:96] ^ t;
   assign n1 = prev_key[95:64] ^ n0;
   assign n2 = prev_key[63:32] ^ n1;
   assign n3 = prev_key[31:0] ^ n2;
   assign next_key = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_key_schedule_seq.sv
// aes_key_schedule_seq: streams AES-128 round keys 0..NR, one expander step per accepted beat
module aes_key_schedule_seq
   import aes_pkg::*;
#(
   parameter int KEY_W = 128,
   parameter int NR    = AES_NR
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [KEY_W-1:0] key_in,
   input  logic             key_valid,
   output logic             key_ready,
   input  logic             abort,
   output logic [KEY_W-1:0] rk_out,
   output logic [3:0]       rk_round,
   output logic             rk_valid,
   input  logic             rk_ready,
   output logic             rk_last,
   output logic             busy
);
   ks_state_t  state, state_nxt;
   block_t     cur_key, key_nxt, exp_key;
   logic [3:0] round_cnt, cnt_nxt;
   logic       last;
   KeyExpansionComb128 u_expand (
      .prev_key (cur_key),
      .round    (round_cnt + 4'd1),
      .next_key (exp_key)
   );
   assign last      = round_cnt == 4'(NR);
   assign key_ready = state == IDLE;
   assign rk_valid  = state == EMIT;
   assign busy      = state != IDLE;
   assign rk_out    = cur_key;
   assign rk_round  = round_cnt;
   assign rk_last   = rk_valid & last;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state     <= IDLE;
         cur_key   <= '0;
         round_cnt <= '0;
      end else begin
         state     <= state_nxt;
         cur_key   <= key_nxt;
         round_cnt <= cnt_nxt;
      end
   // abort outranks both handshakes, so a coincident key_valid is dropped
   always_comb begin
      state_nxt = state;
      key_nxt   = cur_key;
      cnt_nxt   = round_cnt;
      if (abort) begin
         state_nxt = IDLE;
         key_nxt   = '0;
         cnt_nxt   = '0;
      end else if (state == IDLE && key_valid) begin
         state_nxt = EMIT;
         key_nxt   = key_in;
         cnt_nxt   = '0;
      end else if (state == EMIT && rk_ready) begin
         state_nxt = last ? IDLE : EMIT;
         key_nxt   = last ? cur_key : exp_key;
         cnt_nxt   = last ? round_cnt : round_cnt + 4'd1;
      end
   end
endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// tb_aes_key_schedule_seq: random and FIPS-197 key schedules checked against a word-array reference model
module tb_aes_key_schedule_seq;
   logic         clk = 0, reset_n = 0, key_valid = 0, abort = 0, rk_ready = 1;
   logic [127:0] key_in = '0, rk_out;
   logic [3:0]   rk_round;
   logic         key_ready, rk_valid, rk_last, busy;
   int checks = 0, failures = 0;
   logic [7:0]   sb [256];
   logic [127:0] exp_rk [11];
   logic [127:0] obs_rk [11];

   aes_key_schedule_seq dut (
      .clk(clk), .reset_n(reset_n), .key_in(key_in), .key_valid(key_valid),
      .key_ready(key_ready), .abort(abort), .rk_out(rk_out), .rk_round(rk_round),
      .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_last(rk_last), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p = 0;
      for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
      for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h011b << (i - 8);
      return p[7:0];
   endfunction

   function automatic void build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 0, b;
         for (int y = 1; y < 256; y++) if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         b = 8'h63;
         for (int k = 0; k < 5; k++) b ^= (inv << k) | (inv >> (8 - k));
         sb[x] = b;
      end
   endfunction

   function automatic void expand(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
            rc = mul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   task automatic load(input logic [127:0] k);
      key_in = k;
      key_valid = 1;
      @(negedge clk);
      key_valid = 0;
   endtask

   task automatic stream(input logic [127:0] k, input int stall_r, input bit hold, input logic [127:0] k2);
      expand(k);
      if (hold) begin
         key_in = k2;
         key_valid = 1;
      end
      for (int r = 0; r < 11; r++) begin
         check("rk_valid", 128'(rk_valid), 128'd1);
         check("rk_round", 128'(rk_round), 128'(r));
         check("rk_out", rk_out, exp_rk[r]);
         check("rk_last", 128'(rk_last), 128'(r == 10));
         check("key_ready_emit", 128'(key_ready), 128'd0);
         obs_rk[r] = rk_out;
         if (r == stall_r) begin
            rk_ready = 0;
            repeat (3) begin
               @(negedge clk);
               check("stall_valid", 128'(rk_valid), 128'd1);
               check("stall_round", 128'(rk_round), 128'(r));
               check("stall_out", rk_out, exp_rk[r]);
            end
            rk_ready = 1;
         end
         @(negedge clk);
      end
      check("done_valid", 128'(rk_valid), 128'd0);
      check("done_key_ready", 128'(key_ready), 128'd1);
      check("done_busy", 128'(busy), 128'd0);
      if (hold) begin
         @(negedge clk);
         key_valid = 0;
      end
   endtask

   task automatic step_to(input int r);
      while (int'(rk_round) < r) @(negedge clk);
   endtask

   initial begin
      logic [127:0] fips, kb, kc;
      build_sbox();
      #3;
      check("rst_key_ready", 128'(key_ready), 128'd1);
      check("rst_valid", 128'(rk_valid), 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_out", rk_out, 128'd0);
      @(negedge clk);
      reset_n = 1;
      @(negedge clk);
      fips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      load(fips);
      stream(fips, -1, 0, '0);
      check("fips_r0", obs_rk[0], fips);
      check("fips_r1", obs_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
      check("fips_r10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      load('0);
      stream('0, -1, 0, '0);
      check("zero_r1", obs_rk[1], {4{32'h62636363}});
      check("zero_r10", obs_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
      kb = {$urandom, $urandom, $urandom, $urandom};
      load(kb);
      stream(kb, 5, 0, '0);
      kc = {$urandom, $urandom, $urandom, $urandom};
      load(fips);
      stream(fips, -1, 1, kc);
      stream(kc, -1, 0, '0);
      load(kb);
      step_to(4);
      check("abort_round", 128'(rk_round), 128'd4);
      abort = 1;
      key_in = kc;
      key_valid = 1;
      @(negedge clk);
      abort = 0;
      key_valid = 0;
      check("abort_valid", 128'(rk_valid), 128'd0);
      check("abort_busy", 128'(busy), 128'd0);
      check("abort_key_ready", 128'(key_ready), 128'd1);
      @(negedge clk);
      check("abort_no_accept", 128'(rk_valid), 128'd0);
      load(kc);
      stream(kc, -1, 0, '0);
      load(kb);
      step_to(7);
      #2 reset_n = 0;
      #1;
      check("arst_valid", 128'(rk_valid), 128'd0);
      check("arst_busy", 128'(busy), 128'd0);
      check("arst_key_ready", 128'(key_ready), 128'd1);
      check("arst_out", rk_out, 128'd0);
      check("arst_round", 128'(rk_round), 128'd0);
      check("arst_last", 128'(rk_last), 128'd0);
      @(negedge clk);
      reset_n = 1;
      @(negedge clk);
      for (int n = 0; n < 6; n++) begin
         kb = {$urandom, $urandom, $urandom, $urandom};
         load(kb);
         stream(kb, int'($urandom_range(0, 12)), 0, '0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
